// File: rtl/uart_pkg.sv
// Shared UART receiver types and baud-rate helper for the instruction loader.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int BYTES_PER_WORD = 4;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_imem_loader_if.sv
// Instruction-memory write port: one-cycle strobe with word address and data.
interface uart_imem_loader_if #(
    parameter int ADDR_W = 6
);
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;

    modport master (output imem_we, output imem_waddr, output imem_wdata);
    modport slave  (input  imem_we, input  imem_waddr, input  imem_wdata);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling timer and receive FSM.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    output logic       o_byte_valid,
    output logic [7:0] o_byte_data,
    output logic       o_frame_err_pulse
);

    localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
    localparam int HALF  = CPB / 2;
    localparam int CNT_W = $clog2(CPB + 1);

    logic [1:0]       r_sync;
    logic             w_rx_s;
    rx_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_byte_valid;
    logic             r_frame_err_pulse;

    // Synchroniser resets to the idle-high line level so reset never fakes a start bit.
    always_ff @(posedge clk) begin
        if (rst) r_sync <= 2'b11;
        else     r_sync <= {r_sync[0], i_rx};
    end

    assign w_rx_s = r_sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= IDLE;
            r_cnt             <= '0;
            r_bit_idx         <= '0;
            r_shift           <= '0;
            r_byte_valid      <= 1'b0;
            r_frame_err_pulse <= 1'b0;
        end else begin
            r_byte_valid      <= 1'b0;
            r_frame_err_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= START;
                        r_cnt   <= '0;
                    end
                end
                START: begin
                    if (r_cnt == CNT_W'(HALF - 1)) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_state <= IDLE;
                        end else begin
                            r_state   <= DATA;
                            r_bit_idx <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (r_cnt == CNT_W'(CPB - 1)) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_rx_s, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) r_state <= STOP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    // Sampled mid-stop-bit, so IDLE is ready before the next start edge.
                    if (r_cnt == CNT_W'(CPB - 1)) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                        if (w_rx_s) r_byte_valid      <= 1'b1;
                        else        r_frame_err_pulse <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_byte_valid      = r_byte_valid;
    assign o_byte_data       = r_shift;
    assign o_frame_err_pulse = r_frame_err_pulse;

endmodule

// File: rtl/uart_imem_loader.sv
// Boot loader: packs UART bytes MSB-first into words, writes them to imem,
// and holds the core in reset until the whole image has been written.
module uart_imem_loader
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 9600,
    parameter int NUM_BYTES = 256,
    parameter int ADDR_W    = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx,
    uart_imem_loader_if.master  imem,
    output logic                load_done,
    output logic                cpu_rst,
    output logic                frame_err
);

    localparam int                NUM_WORDS = NUM_BYTES / BYTES_PER_WORD;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    logic              w_byte_valid;
    logic [7:0]        w_byte;
    logic              w_frame_err_pulse;
    logic              w_last_wr;
    logic              w_accept;

    logic [23:0]       r_word;
    logic [1:0]        r_byte_idx;
    logic [ADDR_W-1:0] r_word_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [31:0]       r_wdata;
    logic              r_done;
    logic              r_cpu_rst;
    logic              r_frame_err;

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_rx (
        .clk               (clk),
        .rst               (rst),
        .i_rx              (rx),
        .o_byte_valid      (w_byte_valid),
        .o_byte_data       (w_byte),
        .o_frame_err_pulse (w_frame_err_pulse)
    );

    // Bytes are dropped once the final write is in flight or the image is complete.
    assign w_last_wr = r_we && (r_waddr == LAST_ADDR);
    assign w_accept  = w_byte_valid && !r_done && !w_last_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word      <= '0;
            r_byte_idx  <= '0;
            r_word_cnt  <= '0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_done      <= 1'b0;
            r_cpu_rst   <= 1'b1;
            r_frame_err <= 1'b0;
        end else begin
            r_we      <= 1'b0;
            r_cpu_rst <= ~r_done;
            if (w_frame_err_pulse) r_frame_err <= 1'b1;
            if (w_accept) begin
                r_word     <= {r_word[15:0], w_byte};
                r_byte_idx <= r_byte_idx + 2'd1;
                if (r_byte_idx == 2'd3) begin
                    r_we    <= 1'b1;
                    r_waddr <= r_word_cnt;
                    r_wdata <= {r_word, w_byte};
                end
            end
            if (r_we) begin
                r_word_cnt <= r_word_cnt + ADDR_W'(1);
                if (w_last_wr) r_done <= 1'b1;
            end
        end
    end

    assign imem.imem_we    = r_we;
    assign imem.imem_waddr = r_waddr;
    assign imem.imem_wdata = r_wdata;
    assign load_done       = r_done;
    assign cpu_rst         = r_cpu_rst;
    assign frame_err       = r_frame_err;

endmodule
